pattern_ctrl: RTL and testbench
===============================

// Module: pattern_ctrl
// PURPOSE
//  Control FSM of the test-pattern generator. Sequences frames/lines from f_sync/sync/endLine/endFrame,
//  latches the 3-bit pattern Mode and ramp step X per frame, and drives the enables and selects for the
//  Counter12Bit, Counter5Bit, Ramp and Counter datapath blocks and the LoadVal mux.
// PARAMETERS
//  none (all widths fixed by the datapath)
// PORTS
//  clk           in   1  single clock; all state updates on posedge
//  rst_n         in   1  reset, synchronous, ACTIVE-HIGH (1 = reset; name kept from codebase)
//  f_sync        in   1  first sync: frame start, latches Mode/X, starts first line
//  sync          in   1  line start
//  endLine       in   1  current line finished
//  endFrame      in   1  frame finished (priority over endLine)
//  X             in   2  ramp deltaX code
//  Mode          in   3  pattern mode
//  b12_enb       out  1  Counter12Bit enable
//  b5_enb        out  1  Counter5Bit enable
//  ramp_enb      out  1  Ramp enable
//  cnt_enb       out  1  Counter enable
//  test          out  1  1 = test mode
//  newLine       out  1  1-cycle pulse at line start
//  BinaryOrGray  out  1  1 = Gray count, 0 = binary
//  delta         out  1  1-cycle pulse: ramp row start += deltaY
//  Xmode         out  2  deltaX: 00=0, 01=1, 10=4, 11=8
//  ValSel        out  2  LoadVal: 00 ramp, 01 constant, 10 12'b1, 11 counter output
// BEHAVIOUR
//  Reset (rst_n=1 at posedge): state IDLE, mode_q=000, x_q=00, every output 0. Reset overrides all inputs.
//  States: IDLE (no frame), ACTIVE (line running), WAIT_LINE (between lines).
//  Transitions (evaluated each posedge, priority top-down):
//   - f_sync=1, any state: mode_q<=Mode, x_q<=X, ->ACTIVE, newLine<=1 (resync mid-frame allowed).
//   - ACTIVE & endFrame=1: ->IDLE (no delta pulse).
//   - ACTIVE & endLine=1: ->WAIT_LINE; delta<=1 iff mode_q=001.
//   - WAIT_LINE & sync=1: ->ACTIVE, newLine<=1.
//   - WAIT_LINE & endFrame=1: ->IDLE.
//   - IDLE: sync/endLine/endFrame ignored; sync in ACTIVE ignored.
//  newLine/delta registered: high exactly the cycle after the triggering edge, else 0.
//  Mode/X sampled only on f_sync; changes mid-frame have no effect.
//  Mode decode (from mode_q; enables only while state=ACTIVE, selects held in all non-reset states):
//   000 constant : ValSel=01; no enables
//   001 ramp     : ramp_enb; ValSel=00; Xmode=x_q (else Xmode=00)
//   010 walk-one : b12_enb; ValSel=10
//   011 binary   : cnt_enb, b12_enb; BinaryOrGray=0; ValSel=11
//   100 gray     : cnt_enb, b12_enb; BinaryOrGray=1; ValSel=11
//   101 test     : test=1 (all non-reset states); b5_enb, cnt_enb; ValSel=11
//   110/111      : reserved, outputs as 000
//  Enables/selects are combinational from (state, mode_q): first enabled cycle coincides with newLine.
//  Simultaneous endLine+endFrame in ACTIVE -> IDLE, delta stays 0. f_sync+sync together = f_sync.
// STRUCTURE
//  pattern_pkg: mode_e (7 codes above), valsel_e (4 codes), state_e (IDLE/ACTIVE/WAIT_LINE),
//  xmode codes. One natural sub-module: pattern_mode_dec (mode_q, active -> enables/selects, combinational);
//  FSM, latches and pulse registers stay in pattern_ctrl.
// TESTING
//  1 rst_n=1 two cycles, drive random inputs -> all outputs 0, state IDLE.
//  2 Mode=001,X=01, f_sync+sync 1 cycle -> next cycle newLine=1 one cycle, ramp_enb=1, ValSel=00, Xmode=01.
//  3 Same frame, 10 cycles later endLine=1 -> ramp_enb=0 and delta=1 for one cycle; sync -> newLine, ramp_enb=1.
//  4 ACTIVE, endLine=endFrame=1 held -> IDLE, delta=0, enables 0 until next f_sync.
//  5 Mode=100 via f_sync -> cnt_enb=b12_enb=1, BinaryOrGray=1, ValSel=11; Mode changed to 011 mid-frame -> no change.
//  6 Mode=101 -> test=1, b5_enb=1; rst_n=1 mid-line -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and codes for the test-pattern generator control path.
package pattern_pkg;

    typedef enum logic [2:0] {
        ModeConst  = 3'b000,
        ModeRamp   = 3'b001,
        ModeWalk   = 3'b010,
        ModeBinary = 3'b011,
        ModeGray   = 3'b100,
        ModeTest   = 3'b101,
        ModeRsvd   = 3'b110
    } mode_e;

    typedef enum logic [1:0] {
        ValRamp  = 2'b00,
        ValConst = 2'b01,
        ValOne   = 2'b10,
        ValCnt   = 2'b11
    } valsel_e;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StActive   = 2'b01,
        StWaitLine = 2'b10
    } state_e;

    // deltaX codes driven on Xmode
    localparam logic [1:0] XmodeD0 = 2'b00;
    localparam logic [1:0] XmodeD1 = 2'b01;
    localparam logic [1:0] XmodeD4 = 2'b10;
    localparam logic [1:0] XmodeD8 = 2'b11;

endpackage

// File: rtl/pattern_mode_dec.sv
// Combinational decode of the latched pattern mode into datapath enables and selects.
module pattern_mode_dec
    import pattern_pkg::*;
(
    input  logic [2:0] mode_i,
    input  logic [1:0] x_i,
    input  logic       active_i,
    input  logic       valid_i,
    output logic       b12_enb_o,
    output logic       b5_enb_o,
    output logic       ramp_enb_o,
    output logic       cnt_enb_o,
    output logic       test_o,
    output logic       bin_gray_o,
    output logic [1:0] xmode_o,
    output logic [1:0] val_sel_o
);

    // valid_i is low until the first frame after reset, forcing every output to 0
    always_comb begin
        b12_enb_o  = 1'b0;
        b5_enb_o   = 1'b0;
        ramp_enb_o = 1'b0;
        cnt_enb_o  = 1'b0;
        test_o     = 1'b0;
        bin_gray_o = 1'b0;
        xmode_o    = XmodeD0;
        val_sel_o  = 2'b00;
        if (valid_i) begin
            case (mode_i)
                ModeRamp: begin
                    ramp_enb_o = active_i;
                    xmode_o    = x_i;
                    val_sel_o  = ValRamp;
                end
                ModeWalk: begin
                    b12_enb_o = active_i;
                    val_sel_o = ValOne;
                end
                ModeBinary: begin
                    cnt_enb_o = active_i;
                    b12_enb_o = active_i;
                    val_sel_o = ValCnt;
                end
                ModeGray: begin
                    cnt_enb_o  = active_i;
                    b12_enb_o  = active_i;
                    bin_gray_o = 1'b1;
                    val_sel_o  = ValCnt;
                end
                ModeTest: begin
                    test_o    = 1'b1;
                    b5_enb_o  = active_i;
                    cnt_enb_o = active_i;
                    val_sel_o = ValCnt;
                end
                default: val_sel_o = ValConst;
            endcase
        end
    end

endmodule

// File: rtl/pattern_ctrl.sv
// Frame/line sequencer of the test-pattern generator; latches Mode/X per frame.
module pattern_ctrl
    import pattern_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       f_sync,
    input  logic       sync,
    input  logic       endLine,
    input  logic       endFrame,
    input  logic [1:0] X,
    input  logic [2:0] Mode,
    output logic       b12_enb,
    output logic       b5_enb,
    output logic       ramp_enb,
    output logic       cnt_enb,
    output logic       test,
    output logic       newLine,
    output logic       BinaryOrGray,
    output logic       delta,
    output logic [1:0] Xmode,
    output logic [1:0] ValSel
);

    state_e     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [1:0] x_q, x_d;
    logic       valid_q, valid_d;
    logic       new_line_q, new_line_d;
    logic       delta_q, delta_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        x_d        = x_q;
        valid_d    = valid_q;
        new_line_d = 1'b0;
        delta_d    = 1'b0;
        if (f_sync) begin
            mode_d     = Mode;
            x_d        = X;
            valid_d    = 1'b1;
            state_d    = StActive;
            new_line_d = 1'b1;
        end else begin
            case (state_q)
                StActive: begin
                    // endFrame wins over endLine and suppresses the delta pulse
                    if (endFrame) begin
                        state_d = StIdle;
                    end else if (endLine) begin
                        state_d = StWaitLine;
                        delta_d = (mode_q == ModeRamp);
                    end
                end
                StWaitLine: begin
                    if (sync) begin
                        state_d    = StActive;
                        new_line_d = 1'b1;
                    end else if (endFrame) begin
                        state_d = StIdle;
                    end
                end
                StIdle:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 3'b000;
            x_q        <= 2'b00;
            valid_q    <= 1'b0;
            new_line_q <= 1'b0;
            delta_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            valid_q    <= valid_d;
            new_line_q <= new_line_d;
            delta_q    <= delta_d;
        end
    end

    assign newLine = new_line_q;
    assign delta   = delta_q;

    pattern_mode_dec u_mode_dec (
        .mode_i     (mode_q),
        .x_i        (x_q),
        .active_i   (state_q == StActive),
        .valid_i    (valid_q),
        .b12_enb_o  (b12_enb),
        .b5_enb_o   (b5_enb),
        .ramp_enb_o (ramp_enb),
        .cnt_enb_o  (cnt_enb),
        .test_o     (test),
        .bin_gray_o (BinaryOrGray),
        .xmode_o    (Xmode),
        .val_sel_o  (ValSel)
    );

endmodule

// File: tb/tb_pattern_ctrl.sv
// Self-checking bench for pattern_ctrl: directed scenarios followed by randomized traffic.
module tb_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, f_sync, sync, endLine, endFrame;
    logic [1:0] X;
    logic [2:0] Mode;
    logic       b12_enb, b5_enb, ramp_enb, cnt_enb, test, newLine, BinaryOrGray, delta;
    logic [1:0] Xmode, ValSel;

    always #5 clk = ~clk;

    pattern_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_sync       (f_sync),
        .sync         (sync),
        .endLine      (endLine),
        .endFrame     (endFrame),
        .X            (X),
        .Mode         (Mode),
        .b12_enb      (b12_enb),
        .b5_enb       (b5_enb),
        .ramp_enb     (ramp_enb),
        .cnt_enb      (cnt_enb),
        .test         (test),
        .newLine      (newLine),
        .BinaryOrGray (BinaryOrGray),
        .delta        (delta),
        .Xmode        (Xmode),
        .ValSel       (ValSel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: where we are in the frame plus what was latched at frame start.
    bit         m_framed;     // a frame has started since reset
    bit         m_in_line;    // a line is currently being drawn
    bit         m_in_frame;   // between f_sync and endFrame
    int         m_mode;
    logic [1:0] m_x;
    bit         m_nl, m_dl;

    // Per-mode behaviour tables, indexed by mode code.
    const logic [1:0] val_tab [8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1};
    const bit ramp_tab [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    const bit b12_tab  [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    const bit cnt_tab  [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    const bit b5_tab   [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    const bit test_tab [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    const bit gray_tab [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {b12_enb, b5_enb, ramp_enb, cnt_enb, test, newLine, BinaryOrGray, delta,
                Xmode, ValSel};
    endfunction

    function automatic logic [11:0] exp_vec();
        bit         on;
        logic [1:0] xm;
        on = m_in_line;
        xm = (m_mode == 1) ? m_x : 2'b00;
        if (!m_framed) return 12'h000;
        return {on & b12_tab[m_mode], on & b5_tab[m_mode], on & ramp_tab[m_mode],
                on & cnt_tab[m_mode], test_tab[m_mode], m_nl, gray_tab[m_mode], m_dl,
                xm, val_tab[m_mode]};
    endfunction

    task automatic model_edge(input bit r, input bit fs, input bit s, input bit el,
                              input bit ef, input logic [1:0] x, input logic [2:0] m);
        m_nl = 0;
        m_dl = 0;
        if (r) begin
            m_framed = 0; m_in_line = 0; m_in_frame = 0; m_mode = 0; m_x = 2'b00;
        end else if (fs) begin
            m_framed = 1; m_in_frame = 1; m_in_line = 1; m_mode = int'(m); m_x = x;
            m_nl = 1;
        end else if (m_in_frame && m_in_line) begin
            if (ef) begin
                m_in_frame = 0; m_in_line = 0;
            end else if (el) begin
                m_in_line = 0;
                m_dl = (m_mode == 1);
            end
        end else if (m_in_frame) begin
            if (s) begin
                m_in_line = 1; m_nl = 1;
            end else if (ef) begin
                m_in_frame = 0;
            end
        end
    endtask

    // Called at a negedge: drive, let the posedge happen, then compare at the next negedge.
    task automatic step(input string tag, input bit r, input bit fs, input bit s, input bit el,
                        input bit ef, input logic [1:0] x, input logic [2:0] m);
        rst_n = r; f_sync = fs; sync = s; endLine = el; endFrame = ef; X = x; Mode = m;
        @(posedge clk);
        model_edge(r, fs, s, el, ef, x, m);
        @(negedge clk);
        check(tag, {4'h0, dut_vec()}, {4'h0, exp_vec()});
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 0, 0, 0, 0, 0, 2'($urandom), 3'($urandom));
    endtask

    initial begin
        rst_n = 1; f_sync = 0; sync = 0; endLine = 0; endFrame = 0; X = 0; Mode = 0;
        m_framed = 0; m_in_line = 0; m_in_frame = 0; m_mode = 0; m_x = 0; m_nl = 0; m_dl = 0;
        @(negedge clk);

        // 1: reset overrides random inputs
        for (int i = 0; i < 2; i++)
            step("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 3'($urandom));
        check("reset_all_zero", {4'h0, dut_vec()}, 16'h0000);
        idle("idle_after_reset", 2);
        check("idle_still_zero", {4'h0, dut_vec()}, 16'h0000);

        // 2: ramp frame start
        step("ramp_start", 0, 1, 1, 0, 0, 2'b01, 3'b001);
        check("ramp_start_sig", {10'h0, newLine, ramp_enb, Xmode, ValSel}, 16'b11_0100);
        idle("ramp_line", 1);
        check("newline_one_cycle", {15'h0, newLine}, 16'h0);

        // 3: line end, delta pulse, next line
        idle("ramp_line", 9);
        step("ramp_endline", 0, 0, 0, 1, 0, 2'b11, 3'b010);
        check("delta_pulse", {14'h0, ramp_enb, delta}, 16'b01);
        idle("ramp_wait", 1);
        check("delta_one_cycle", {15'h0, delta}, 16'h0);
        step("ramp_sync", 0, 0, 1, 0, 0, 2'b00, 3'b000);
        check("second_line", {14'h0, newLine, ramp_enb}, 16'b11);

        // 4: endLine+endFrame together end the frame with no delta
        step("both_end", 0, 0, 0, 1, 1, 2'b00, 3'b000);
        check("both_end_sig", {14'h0, ramp_enb, delta}, 16'b00);
        step("both_end_hold", 0, 0, 1, 1, 1, 2'b00, 3'b000);
        step("idle_sync", 0, 0, 1, 0, 0, 2'b00, 3'b000);
        check("idle_no_enable", {12'h0, b12_enb, b5_enb, ramp_enb, cnt_enb}, 16'h0);

        // 5: gray frame ignores mid-frame Mode change
        step("gray_start", 0, 1, 0, 0, 0, 2'b10, 3'b100);
        check("gray_sig", {11'h0, cnt_enb, b12_enb, BinaryOrGray, ValSel}, 16'b1_1_1_11);
        for (int i = 0; i < 4; i++)
            step("gray_modechg", 0, 0, 1, 0, 0, 2'b00, 3'b011);
        check("gray_held", {11'h0, cnt_enb, b12_enb, BinaryOrGray, ValSel}, 16'b1_1_1_11);

        // 6: test mode, then reset mid-line
        step("test_start", 0, 1, 0, 0, 0, 2'b00, 3'b101);
        check("test_sig", {14'h0, test, b5_enb}, 16'b11);
        idle("test_line", 3);
        step("test_reset", 1, 0, 0, 0, 0, 2'b00, 3'b101);
        check("reset_mid_line", {4'h0, dut_vec()}, 16'h0000);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step("random",
                 ($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(9) == 0),
                 2'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
